// File: rtl/pc_sequencer_if.sv
// Instruction-fetch and redirect bundle between the PC sequencer, instruction memory and ID.
// The master side is the sequencer and the slave side is imem/decode.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_ready;
  logic              stall;
  logic              branch_req;
  logic              branch_taken;
  logic [15:0]       branch_imm;
  logic              jump_req;
  logic [25:0]       jump_index;
  logic              jr_req;
  logic [ADDR_W-1:0] jr_addr;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic [ADDR_W-1:0] id_pc;
  logic              flush;
  logic              addr_err;

  modport master (
    input  fetch_ready, stall, branch_req, branch_taken, branch_imm,
           jump_req, jump_index, jr_req, jr_addr,
    output pc, pc_valid, id_pc, flush, addr_err
  );

  modport slave (
    output fetch_ready, stall, branch_req, branch_taken, branch_imm,
           jump_req, jump_index, jr_req, jr_addr,
    input  pc, pc_valid, id_pc, flush, addr_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner for the MIPS front end: picks sequential, branch, jump or JR
// targets, handshakes with imem, and flushes the wrong-path fetch on a redirect.
module pc_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, REDIR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_q, pc_next;
  logic [ADDR_W-1:0] id_pc_q, id_pc_next;
  logic              addr_err_q, addr_err_next;

  logic              fire;
  logic              redirect;
  logic [ADDR_W-1:0] id_pc_plus4;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] target;

  assign bus.pc       = pc_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.pc_valid = (state == FETCH) || (state == WAIT);
  assign bus.flush    = (state == REDIR);
  assign bus.addr_err = addr_err_q;

  assign fire        = bus.pc_valid && bus.fetch_ready;
  assign redirect    = bus.jr_req || bus.jump_req || (bus.branch_req && bus.branch_taken);
  assign id_pc_plus4 = id_pc_q + ADDR_W'(4);
  assign branch_off  = {{(ADDR_W-18){bus.branch_imm[15]}}, bus.branch_imm, 2'b00};

  // Redirect target with JR taking precedence over J/JAL, then a taken branch
  always_comb begin
    target = id_pc_plus4 + branch_off;
    if (bus.jr_req) begin
      target = {bus.jr_addr[ADDR_W-1:2], 2'b00};
    end else if (bus.jump_req) begin
      target = {id_pc_plus4[ADDR_W-1:28], bus.jump_index, 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      id_pc_q    <= id_pc_next;
      addr_err_q <= addr_err_next;
    end
  end

  // Redirects are only honoured while a real instruction sits in ID (FETCH/WAIT) and
  // ID is not stalled; a redirect beats a simultaneous fire, so id_pc stays put.
  always_comb begin
    state_next    = state;
    pc_next       = pc_q;
    id_pc_next    = id_pc_q;
    addr_err_next = 1'b0;
    case (state)
      BOOT:  state_next = FETCH;
      REDIR: state_next = FETCH;
      FETCH, WAIT: begin
        if (!bus.stall && redirect) begin
          pc_next       = target;
          state_next    = REDIR;
          addr_err_next = bus.jr_req && (bus.jr_addr[1:0] != 2'b00);
        end else if (fire) begin
          state_next = FETCH;
          if (!bus.stall) begin
            id_pc_next = pc_q;
            pc_next    = pc_q + ADDR_W'(4);
          end
        end else begin
          state_next = WAIT;
        end
      end
      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential fetch, imem wait, branch,
// jump, JR priority/alignment, redirect in WAIT, wrap-around, stall and async reset.
module tb_pc_sequencer;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fr, input logic st, input logic br,
                               input logic bt, input logic [15:0] imm,
                               input logic jq, input logic [25:0] idx,
                               input logic jrq, input logic [31:0] jra);
    bus.fetch_ready  = fr;
    bus.stall        = st;
    bus.branch_req   = br;
    bus.branch_taken = bt;
    bus.branch_imm   = imm;
    bus.jump_req     = jq;
    bus.jump_index   = idx;
    bus.jr_req       = jrq;
    bus.jr_addr      = jra;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    step();
    tests_run++;
    if (bus.pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc, 32'h0);
    end
    tests_run++;
    if ({bus.pc_valid, bus.flush, bus.addr_err} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected %b",
               {bus.pc_valid, bus.flush, bus.addr_err}, 3'b000);
    end
    tests_run++;
    if (bus.id_pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_id_pc: got %h expected %h", bus.id_pc, 32'h0);
    end
    rst = 1'b0;
    tests_run++;
    if (bus.pc_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL boot_no_valid: got %b expected %b", bus.pc_valid, 1'b0);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (bus.pc !== exp_pc[i] || bus.pc_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL seq_pc[%0d]: got %h/%b expected %h/1", i, bus.pc, bus.pc_valid,
                 exp_pc[i]);
      end
    end
  endtask

  task automatic test_wait();
    // Hold fetch_ready low starting at pc=8: rewind by re-running from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (bus.pc !== 32'h8 || bus.pc_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL wait_hold[%0d]: got %h/%b expected %h/1", i, bus.pc,
                 bus.pc_valid, 32'h8);
      end
    end
    bus.fetch_ready = 1'b1;
    step();
    tests_run++;
    if (bus.pc !== 32'hC || bus.id_pc !== 32'h8) begin
      tests_failed++;
      $display("[TB] FAIL wait_release: got pc %h id_pc %h expected %h %h", bus.pc,
               bus.id_pc, 32'hC, 32'h8);
    end
  endtask

  task automatic test_branch();
    int budget;
    budget = 200;
    while (bus.pc !== 32'h104 && budget > 0) begin
      step();
      budget--;
    end
    tests_run++;
    if (bus.id_pc !== 32'h100) begin
      tests_failed++;
      $display("[TB] FAIL branch_setup: got id_pc %h expected %h (budget %0d)", bus.id_pc,
               32'h100, budget);
    end
    bus.branch_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_imm = 16'hFFFE;
    step();
    bus.branch_req = 1'b0; bus.branch_taken = 1'b0;
    tests_run++;
    if (bus.pc !== 32'h0FC || bus.flush !== 1'b1 || bus.id_pc !== 32'h100) begin
      tests_failed++;
      $display("[TB] FAIL branch_taken: got pc %h flush %b id_pc %h expected %h 1 %h",
               bus.pc, bus.flush, bus.id_pc, 32'h0FC, 32'h100);
    end
    step();
    tests_run++;
    if (bus.flush !== 1'b0 || bus.pc !== 32'h0FC || bus.pc_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL branch_after: got flush %b pc %h valid %b expected 0 %h 1",
               bus.flush, bus.pc, bus.pc_valid, 32'h0FC);
    end
    step();
    bus.branch_req = 1'b1; bus.branch_taken = 1'b0;
    step();
    bus.branch_req = 1'b0;
    tests_run++;
    if (bus.pc !== 32'h104 || bus.flush !== 1'b0 || bus.id_pc !== 32'h100) begin
      tests_failed++;
      $display("[TB] FAIL branch_not_taken: got pc %h flush %b id_pc %h expected %h 0 %h",
               bus.pc, bus.flush, bus.id_pc, 32'h104, 32'h100);
    end
  endtask

  task automatic test_jump();
    bus.jr_req = 1'b1; bus.jr_addr = 32'h9000_0010;
    step();
    bus.jr_req = 1'b0;
    step();
    step();
    tests_run++;
    if (bus.id_pc !== 32'h9000_0010 || bus.pc !== 32'h9000_0014) begin
      tests_failed++;
      $display("[TB] FAIL jump_setup: got id_pc %h pc %h expected %h %h", bus.id_pc,
               bus.pc, 32'h9000_0010, 32'h9000_0014);
    end
    bus.jump_req = 1'b1; bus.jump_index = 26'h0000040;
    step();
    bus.jump_req = 1'b0;
    tests_run++;
    if (bus.pc !== 32'h9000_0100 || bus.flush !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL jump_target: got pc %h flush %b expected %h 1", bus.pc,
               bus.flush, 32'h9000_0100);
    end
    step();
  endtask

  task automatic test_jr_priority();
    bus.jr_req = 1'b1; bus.jr_addr = 32'h0000_2003;
    bus.jump_req = 1'b1; bus.jump_index = 26'h0000040;
    step();
    bus.jr_req = 1'b0; bus.jump_req = 1'b0;
    tests_run++;
    if (bus.pc !== 32'h2000 || bus.addr_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL jr_priority: got pc %h addr_err %b expected %h 1", bus.pc,
               bus.addr_err, 32'h2000);
    end
    step();
    tests_run++;
    if (bus.addr_err !== 1'b0 || bus.pc !== 32'h2000) begin
      tests_failed++;
      $display("[TB] FAIL jr_err_pulse: got addr_err %b pc %h expected 0 %h", bus.addr_err,
               bus.pc, 32'h2000);
    end
  endtask

  task automatic test_wait_redirect_wrap();
    bus.fetch_ready = 1'b0;
    step();
    bus.jr_req = 1'b1; bus.jr_addr = 32'hFFFF_FFFC;
    step();
    bus.jr_req = 1'b0;
    tests_run++;
    if (bus.pc !== 32'hFFFF_FFFC || bus.flush !== 1'b1 || bus.addr_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wait_redirect: got pc %h flush %b err %b expected %h 1 0", bus.pc,
               bus.flush, bus.addr_err, 32'hFFFF_FFFC);
    end
    bus.fetch_ready = 1'b1;
    step();
    step();
    tests_run++;
    if (bus.pc !== 32'h0 || bus.id_pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("[TB] FAIL wrap: got pc %h id_pc %h expected %h %h", bus.pc, bus.id_pc,
               32'h0, 32'hFFFF_FFFC);
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.branch_req = 1'b1; bus.branch_taken = 1'b1;
    bus.branch_imm = 16'h0040;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (bus.pc !== 32'h0 || bus.flush !== 1'b0 || bus.id_pc !== 32'hFFFF_FFFC) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold[%0d]: got pc %h flush %b id_pc %h expected %h 0 %h",
                 i, bus.pc, bus.flush, bus.id_pc, 32'h0, 32'hFFFF_FFFC);
      end
    end
    bus.stall = 1'b0; bus.branch_req = 1'b0; bus.branch_taken = 1'b0;
    step();
    tests_run++;
    if (bus.pc !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got %h expected %h", bus.pc, 32'h4);
    end
  endtask

  task automatic test_reset_mid_wait();
    bus.fetch_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0 || bus.id_pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got pc %h valid %b id_pc %h expected 0 0 0", bus.pc,
               bus.pc_valid, bus.id_pc);
    end
    step();
    rst = 1'b0;
    bus.fetch_ready = 1'b1;
    step();
    tests_run++;
    if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_recover: got pc %h valid %b expected 0 1", bus.pc,
               bus.pc_valid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_sequential();
    test_wait();
    test_branch();
    test_jump();
    test_jr_priority();
    test_wait_redirect_wrap();
    test_stall();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
